// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and constants for the slice configuration-chain loader.
package cfg_pkg;

   // Loader sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // 4 LUTs x 2 x 17 bits, plus use_cc, plus 2 output-mux bits.
   localparam int CHAIN_LEN_DEF = 139;
   localparam int WORD_W_DEF    = 32;

   // Number of bitstream words needed to cover a chain of len bits.
   function automatic int nwords(input int len, input int w);
      return (len + w - 1) / w;
   endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Bitstream word stream (valid/ready) between the source and the loader.
interface cfg_chain_loader_if
   import cfg_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
) ();

   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/cfg_word_serializer.sv
// One-word holding register feeding a shift register, emitting bits LSB-first.
// A bit is available whenever the shift register or the holding register has
// data; take consumes exactly one bit. When the shift register is empty the
// bit comes straight from hold[0] and the rest of the word moves into the
// shift register, so word boundaries cost no bubble.
module cfg_word_serializer
   import cfg_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic [WORD_W-1:0] din,
   input  logic              take,
   output logic              bit_out,
   output logic              empty,
   output logic              hold_v
);

   localparam int SC_W = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] hold_reg;
   logic              hold_v_reg;
   logic [WORD_W-1:0] sh_reg;
   logic [SC_W-1:0]   sh_cnt_reg;
   logic              sh_from_hold;

   assign hold_v       = hold_v_reg;
   assign empty        = (sh_cnt_reg == '0) && !hold_v_reg;
   assign bit_out      = (sh_cnt_reg != '0) ? sh_reg[0] : hold_reg[0];
   assign sh_from_hold = take && (sh_cnt_reg == '0);

   // Holding register: filled by an accepted word, emptied when it moves to sh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_reg   <= '0;
         hold_v_reg <= 1'b0;
      end else if (clr) begin
         hold_reg   <= '0;
         hold_v_reg <= 1'b0;
      end else if (load) begin
         hold_reg   <= din;
         hold_v_reg <= 1'b1;
      end else if (sh_from_hold) begin
         hold_v_reg <= 1'b0;
      end
   end

   // Shift register: bit 0 leaves on each take, refilled from hold when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_reg     <= '0;
         sh_cnt_reg <= '0;
      end else if (clr) begin
         sh_reg     <= '0;
         sh_cnt_reg <= '0;
      end else if (take) begin
         if (sh_cnt_reg != '0) begin
            sh_reg     <= sh_reg >> 1;
            sh_cnt_reg <= sh_cnt_reg - SC_W'(1);
         end else begin
            sh_reg     <= hold_reg >> 1;
            sh_cnt_reg <= SC_W'(WORD_W - 1);
         end
      end
   end

endmodule

// File: rtl/cfg_chain_loader.sv
// Writer side of the slice config chain: takes bitstream words from a
// valid/ready stream and shifts exactly CHAIN_LEN bits into the chain.
module cfg_chain_loader
   import cfg_pkg::*;
#(
   parameter int WORD_W    = WORD_W_DEF,
   parameter int CHAIN_LEN = CHAIN_LEN_DEF,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   cfg_chain_loader_if.slave s_if,
   output logic         cfg_out,
   output logic         cfg_en,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam int NWORDS = nwords(CHAIN_LEN, WORD_W);
   localparam int WR_W   = $clog2(NWORDS + 1);

   state_t            state_reg;
   state_t            state_next;
   logic [CNT_W-1:0]  bit_cnt_reg;
   logic [WR_W-1:0]   words_rcvd_reg;
   logic              done_reg;
   logic              err_reg;
   logic              cfg_en_reg;
   logic              cfg_out_reg;

   logic              ser_clr;
   logic              ser_take;
   logic              ser_empty;
   logic              ser_hold_v;
   logic              ser_bit;
   logic              accept;
   logic              last_bit;

   assign busy    = (state_reg == ST_FILL) || (state_reg == ST_SHIFT);
   assign done    = done_reg;
   assign err     = err_reg;
   assign cfg_en  = cfg_en_reg;
   assign cfg_out = cfg_out_reg;

   // Never ask for more words than the chain needs.
   assign s_if.s_ready = busy && !ser_hold_v && (words_rcvd_reg < WR_W'(NWORDS));
   assign accept       = s_if.s_valid && s_if.s_ready;
   assign last_bit     = (bit_cnt_reg == CNT_W'(CHAIN_LEN - 1));

   cfg_word_serializer #(
      .WORD_W (WORD_W)
   ) u_ser (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (ser_clr),
      .load    (accept),
      .din     (s_if.s_data),
      .take    (ser_take),
      .bit_out (ser_bit),
      .empty   (ser_empty),
      .hold_v  (ser_hold_v)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state and serializer control; abort beats everything while busy.
   // Shifting runs in FILL too so the first bit leaves the cycle the first
   // word lands in the holding register; an empty serializer is a stall.
   always_comb begin
      state_next = state_reg;
      ser_clr    = 1'b0;
      ser_take   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_FILL;
               ser_clr    = 1'b1;
            end
         end
         ST_FILL, ST_SHIFT: begin
            if (abort) begin
               state_next = ST_IDLE;
               ser_clr    = 1'b1;
            end else begin
               ser_take = !ser_empty;
               if (ser_take && last_bit) begin
                  state_next = ST_FIN;
               end else if ((state_reg == ST_FILL) && ser_hold_v) begin
                  state_next = ST_SHIFT;
               end
            end
         end
         ST_FIN: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Registered chain outputs, bit/word counters and sticky status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_en_reg     <= 1'b0;
         cfg_out_reg    <= 1'b0;
         bit_cnt_reg    <= '0;
         words_rcvd_reg <= '0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         cfg_en_reg  <= ser_take;
         cfg_out_reg <= ser_take & ser_bit;
         if ((state_reg == ST_IDLE) && start) begin
            bit_cnt_reg    <= '0;
            words_rcvd_reg <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
         end else begin
            if (ser_take) begin
               bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
            if (accept) begin
               words_rcvd_reg <= words_rcvd_reg + WR_W'(1);
            end
            if (ser_take && last_bit) begin
               done_reg <= 1'b1;
            end
            if (busy && abort) begin
               err_reg <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: drives a word source, captures the
// serial chain stream and compares it with the expected LSB-first bitstream.
module tb_cfg_chain_loader;

   localparam int CL = 139;

   logic clk;
   logic rst_n;
   logic start;
   logic abort;
   logic cfg_out;
   logic cfg_en;
   logic busy;
   logic done;
   logic err;

   cfg_chain_loader_if #(.WORD_W(32)) s_if ();

   cfg_chain_loader dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .abort   (abort),
      .s_if    (s_if),
      .cfg_out (cfg_out),
      .cfg_en  (cfg_en),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] words [0:5];

   // source state
   int     src_idx, src_n, stall_at, stall_len, stall_cnt, hs_count;
   bit     stall_arm, hs_last;
   longint first_hs_t;

   // capture state
   logic   bits [0:199];
   int     nbits, gaps, zero_bad;
   longint first_en_t;

   int     mism;
   int     load_no = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Word source: offers words in order, counts handshakes, optional stall.
   initial begin
      s_if.s_valid = 1'b0;
      s_if.s_data  = '0;
      forever begin
         @(negedge clk);
         if (hs_last) begin
            src_idx++;
            if (src_idx == stall_at) stall_arm = 1'b1;
         end
         if (stall_arm && s_if.s_ready === 1'b1) begin
            stall_cnt = stall_len;
            stall_arm = 1'b0;
         end
         if (stall_cnt > 0) begin
            s_if.s_valid = 1'b0;
            stall_cnt--;
         end else if (src_idx < src_n) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = words[src_idx];
         end else begin
            s_if.s_valid = 1'b0;
         end
         hs_last = s_if.s_valid && (s_if.s_ready === 1'b1);
         if (hs_last) begin
            hs_count++;
            if (first_hs_t < 0) first_hs_t = $time;
         end
      end
   end

   // Chain capture: records each enabled bit, counts stall cycles mid-load.
   initial begin
      zero_bad = 0;
      forever begin
         @(negedge clk);
         if (cfg_en === 1'b1) begin
            if (nbits < 200) bits[nbits] = cfg_out;
            nbits++;
            if (first_en_t < 0) first_en_t = $time;
         end else begin
            if (cfg_out !== 1'b0) zero_bad++;
            if (busy === 1'b1 && nbits > 0) gaps++;
         end
      end
   end

   task automatic prep(input int n_offer, input int st_at, input int st_len);
      src_idx    = 0;
      src_n      = n_offer;
      stall_at   = st_at;
      stall_len  = st_len;
      stall_cnt  = 0;
      stall_arm  = 1'b0;
      hs_last    = 1'b0;
      hs_count   = 0;
      first_hs_t = -1;
      nbits      = 0;
      gaps       = 0;
      first_en_t = -1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
   endtask

   task automatic wait_bits(input int n);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (nbits >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      chk("wait_bits_timeout", 64'(ok), 64'd1);
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      chk("wait_done_timeout", 64'(ok), 64'd1);
      repeat (2) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic count_mism(output int m);
      logic [31:0] w;
      m = 0;
      for (int i = 0; i < CL; i++) begin
         w = words[i / 32];
         if (bits[i] !== w[i % 32]) m++;
      end
   endtask

   task automatic report();
      load_no++;
      $display("load %0d: bits=%0d words=%0d gaps=%0d done=%0b err=%0b",
               load_no, nbits, hs_count, gaps, done, err);
   endtask

   initial begin
      words[0] = 32'hFFFF_FFFF;
      words[1] = 32'h0000_0000;
      words[2] = 32'hA5A5_A5A5;
      words[3] = 32'h1234_5678;
      words[4] = 32'hDEAD_BEEF;
      words[5] = 32'hCAFE_F00D;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      prep(5, 99, 0);

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", 64'({s_if.s_ready, cfg_out, cfg_en, busy, done, err}), 64'd0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;

      // back-to-back load
      prep(5, 99, 0);
      pulse_start();
      wait_done();
      report();
      count_mism(mism);
      chk("b2b_bits", 64'(nbits), 64'd139);
      chk("b2b_mism", 64'(mism), 64'd0);
      chk("b2b_gaps", 64'(gaps), 64'd0);
      chk("b2b_latency", 64'(first_en_t - first_hs_t), 64'd20);
      chk("b2b_words", 64'(hs_count), 64'd5);
      chk("b2b_status", 64'({done, busy, err}), 64'b100);

      // source stall long enough to drain the holding register
      prep(5, 2, 40);
      pulse_start();
      wait_done();
      report();
      count_mism(mism);
      chk("stall_bits", 64'(nbits), 64'd139);
      chk("stall_mism", 64'(mism), 64'd0);
      chk("stall_gap_seen", 64'(gaps != 0), 64'd1);
      chk("stall_err", 64'(err), 64'd0);

      // six words offered, only five accepted
      prep(6, 99, 0);
      pulse_start();
      wait_bits(110);
      chk("extra_ready_low", 64'(s_if.s_ready), 64'd0);
      chk("extra_words_mid", 64'(hs_count), 64'd5);
      wait_done();
      report();
      chk("extra_words_end", 64'(hs_count), 64'd5);
      chk("extra_pending", 64'({s_if.s_valid, s_if.s_data}), {31'd0, 1'b1, 32'hCAFE_F00D});
      chk("extra_bits", 64'(nbits), 64'd139);

      // abort after 50 bits, then a clean reload
      prep(5, 99, 0);
      pulse_start();
      wait_bits(50);
      pulse_abort();
      report();
      chk("abort_cfg_en", 64'(cfg_en), 64'd0);
      chk("abort_status", 64'({done, busy, err}), 64'b001);
      chk("abort_bits", 64'(nbits), 64'd50);
      prep(5, 99, 0);
      pulse_start();
      chk("reload_err_clr", 64'(err), 64'd0);
      wait_done();
      report();
      count_mism(mism);
      chk("reload_bits", 64'(nbits), 64'd139);
      chk("reload_mism", 64'(mism), 64'd0);
      chk("reload_done", 64'({done, err}), 64'b10);

      // start while busy is ignored
      prep(5, 99, 0);
      pulse_start();
      wait_bits(70);
      pulse_start();
      wait_done();
      report();
      count_mism(mism);
      chk("restart_bits", 64'(nbits), 64'd139);
      chk("restart_words", 64'(hs_count), 64'd5);
      chk("restart_mism", 64'(mism), 64'd0);

      // asynchronous reset mid-load
      prep(5, 99, 0);
      pulse_start();
      wait_bits(100);
      rst_n = 1'b0;
      #1;
      chk("async_reset", 64'({s_if.s_ready, cfg_out, cfg_en, busy, done, err}), 64'd0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      prep(5, 99, 0);
      pulse_start();
      wait_done();
      report();
      count_mism(mism);
      chk("post_reset_bits", 64'(nbits), 64'd139);
      chk("post_reset_mism", 64'(mism), 64'd0);
      chk("post_reset_done", 64'(done), 64'd1);

      chk("cfg_out_zero_when_idle", 64'(zero_bad), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
